exp_adder_pipe: RTL and testbench

- Parametrised, pipelined exponent unit for the floating-point multiplier datapath.
- Adds two biased exponents, removes the bias, and applies the mantissa-normalisation increment.
- Detects overflow, underflow and zero operands.
- Sits between operand unpack and result pack; moves data with a valid/ready handshake so it can stall with the mantissa multiplier.

---
 rtl/exp_adder_pipe.sv | 146 ++++++++++++++
 tb/tb_exp_adder_pipe.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/exp_adder_pipe.sv
// exp_adder_pipe: two-stage exponent unit for the floating-point multiplier.
// Stage 1 adds the two biased exponents plus the normalisation increment.
// Stage 2 removes the bias, classifies the result (zero / overflow / underflow)
// and registers the outputs.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready are
// both high. Input transfer = i_valid & o_ready, output transfer =
// o_valid & i_ready. o_ready depends combinationally on i_ready, so a full
// pipe keeps accepting one operand set per cycle while downstream drains it.
//
// Build option: define EXP_ADDER_SAT_EN to saturate o_exponente on overflow
// (all ones) and underflow (zero). Without it the exponent wraps and only the
// flags report the out-of-range result.
module exp_adder_pipe #(
  parameter int NB_EXP = 4,
  parameter int BIAS   = 7
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [NB_EXP-1:0] i_exponente_1,
  input  logic [NB_EXP-1:0] i_exponente_2,
  input  logic              i_norm_inc,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [NB_EXP-1:0] o_exponente,
  output logic              o_zero,
  output logic              o_overflow,
  output logic              o_underflow
);

  // Two guard bits: one for the carry of A+B+inc, one for the sign after
  // the bias is removed.
  localparam int SW = NB_EXP + 2;

  localparam logic signed [SW-1:0] BIAS_S  = SW'(BIAS);
  localparam logic signed [SW-1:0] EXP_MAX = SW'((1 << NB_EXP) - 1);

  // Stage 1 state
  logic          v1;
  logic [SW-1:0] sum1;
  logic          zero1;

  // Stage 2 state (drives the outputs directly)
  logic              v2;
  logic [NB_EXP-1:0] exp2;
  logic              zero2;
  logic              ovf2;
  logic              unf2;

  // Advance controls
  logic load1;
  logic load2;

  // Stage 1 combinational results
  logic [SW-1:0] sum_in;
  logic          zero_in;

  // Stage 2 combinational results
  logic signed [SW-1:0] diff;
  logic                 ovf_raw;
  logic                 unf_raw;
  logic                 ovf_next;
  logic                 unf_next;
  logic [NB_EXP-1:0]    exp_next;

  // Stage 2 may load when it is empty or its result is leaving this cycle;
  // stage 1 may load when it is empty or can push into stage 2.
  always_comb begin
    load2 = !v2 || i_ready;
    load1 = !v1 || load2;
  end

  assign o_ready = load1;

  // Stage 1 datapath: zero-extended sum of both exponents and the increment.
  always_comb begin
    sum_in  = {2'b00, i_exponente_1} + {2'b00, i_exponente_2}
            + {{(SW-1){1'b0}}, i_norm_inc};
    zero_in = (i_exponente_1 == '0) || (i_exponente_2 == '0);
  end

  // Stage 1 register: valid follows the input on every advance; data only
  // changes when a new operand set actually arrives.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      v1    <= 1'b0;
      sum1  <= '0;
      zero1 <= 1'b0;
    end else if (load1) begin
      v1 <= i_valid;
      if (i_valid) begin
        sum1  <= sum_in;
        zero1 <= zero_in;
      end
    end
  end

  // Stage 2 datapath: unbias and classify with priority zero > over > under.
  always_comb begin
    diff     = $signed(sum1) - BIAS_S;
    ovf_raw  = !diff[SW-1] && (diff > EXP_MAX);
    unf_raw  = diff[SW-1] || (diff == '0);
    ovf_next = !zero1 && ovf_raw;
    unf_next = !zero1 && !ovf_raw && unf_raw;
    exp_next = diff[NB_EXP-1:0];
    if (zero1) begin
      exp_next = '0;
    end
`ifdef EXP_ADDER_SAT_EN
    else if (ovf_next) begin
      exp_next = '1;
    end else if (unf_next) begin
      exp_next = '0;
    end
`endif
  end

  // Stage 2 register: holds while stalled; data is kept across bubbles so
  // the outputs never change while o_valid is low.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      v2    <= 1'b0;
      exp2  <= '0;
      zero2 <= 1'b0;
      ovf2  <= 1'b0;
      unf2  <= 1'b0;
    end else if (load2) begin
      v2 <= v1;
      if (v1) begin
        exp2  <= exp_next;
        zero2 <= zero1;
        ovf2  <= ovf_next;
        unf2  <= unf_next;
      end
    end
  end

  assign o_valid     = v2;
  assign o_exponente = exp2;
  assign o_zero      = zero2;
  assign o_overflow  = ovf2;
  assign o_underflow = unf2;

endmodule

// File: tb/tb_exp_adder_pipe.sv
// tb_exp_adder_pipe: directed bench for exp_adder_pipe (NB_EXP=4, BIAS=7).
// Expected results are hand-computed; saturating-build values are selected
// with EXP_ADDER_SAT_EN so the bench matches whichever build it is paired with.
module tb_exp_adder_pipe;

  localparam int NB_EXP = 4;
  localparam int BIAS   = 7;

  logic              clk;
  logic              i_reset;
  logic              i_valid;
  logic              o_ready;
  logic [NB_EXP-1:0] i_exponente_1;
  logic [NB_EXP-1:0] i_exponente_2;
  logic              i_norm_inc;
  logic              o_valid;
  logic              i_ready;
  logic [NB_EXP-1:0] o_exponente;
  logic              o_zero;
  logic              o_overflow;
  logic              o_underflow;

  int n_vec = 0;
  int n_err = 0;

  // {exponent, zero, overflow, underflow}
  logic [NB_EXP+2:0] exp_q[$];

  exp_adder_pipe #(.NB_EXP(NB_EXP), .BIAS(BIAS)) dut (
    .clk           (clk),
    .i_reset       (i_reset),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_exponente_1 (i_exponente_1),
    .i_exponente_2 (i_exponente_2),
    .i_norm_inc    (i_norm_inc),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_exponente   (o_exponente),
    .o_zero        (o_zero),
    .o_overflow    (o_overflow),
    .o_underflow   (o_underflow)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic int ovf_exp(input int wrapped);
`ifdef EXP_ADDER_SAT_EN
    return 15;
`else
    return wrapped;
`endif
  endfunction

  function automatic int unf_exp(input int wrapped);
`ifdef EXP_ADDER_SAT_EN
    return 0;
`else
    return wrapped;
`endif
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [NB_EXP+2:0] e);
    chk({tag, "_exp"}, int'(o_exponente), int'(e[NB_EXP+2:3]));
    chk({tag, "_zero"}, int'(o_zero), int'(e[2]));
    chk({tag, "_ovf"}, int'(o_overflow), int'(e[1]));
    chk({tag, "_unf"}, int'(o_underflow), int'(e[0]));
  endtask

  function automatic logic [NB_EXP+2:0] pack(input int e, input bit z,
                                             input bit o, input bit u);
    return {e[NB_EXP-1:0], z, o, u};
  endfunction

  // Driver: one operand set with i_ready=1; checks 2-cycle latency.
  // Entered and left at posedge+1.
  task automatic run_one(input string tag, input int a, input int b,
                         input bit inc, input logic [NB_EXP+2:0] e);
    i_ready       = 1'b1;
    i_valid       = 1'b1;
    i_exponente_1 = a[NB_EXP-1:0];
    i_exponente_2 = b[NB_EXP-1:0];
    i_norm_inc    = inc;
    @(posedge clk); #1;
    i_valid = 1'b0;
    chk({tag, "_lat1_valid"}, int'(o_valid), 0);
    @(posedge clk); #1;
    chk({tag, "_lat2_valid"}, int'(o_valid), 1);
    chk_out(tag, e);
  endtask

  logic [NB_EXP+2:0] bp_exp[4];
  int bp_a[4];
  int bp_b[4];
  bit bp_inc[4];

  initial begin
    int next_in;
    int n_out;
    bit will_in;
    bit will_out;

    i_reset       = 1'b1;
    i_valid       = 1'b0;
    i_ready       = 1'b1;
    i_exponente_1 = '0;
    i_exponente_2 = '0;
    i_norm_inc    = 1'b0;

    // Reset state
    #12;
    chk("rst_valid", int'(o_valid), 0);
    chk_out("rst", pack(0, 0, 0, 0));
    @(posedge clk); #1;
    i_reset = 1'b0;
    #1;
    chk("rst_ready", int'(o_ready), 1);
    @(posedge clk); #1;

    // Main function and boundaries
    run_one("add9_10",      9, 10, 0, pack(12, 0, 0, 0));
    run_one("add9_10_inc",  9, 10, 1, pack(13, 0, 0, 0));
    run_one("ovf15_15_inc", 15, 15, 1, pack(ovf_exp(8), 0, 1, 0));
    run_one("unf3_2",       3, 2, 0, pack(unf_exp(14), 0, 0, 1));
    run_one("unf3_4",       3, 4, 0, pack(0, 0, 0, 1));
    run_one("zero0_12",     0, 12, 0, pack(0, 1, 0, 0));
    run_one("zero12_0_inc", 12, 0, 1, pack(0, 1, 0, 0));
    run_one("max11_11",     11, 11, 0, pack(15, 0, 0, 0));
    run_one("ovf11_11_inc", 11, 11, 1, pack(ovf_exp(0), 0, 1, 0));
    run_one("min4_4",       4, 4, 0, pack(1, 0, 0, 0));

    // Backpressure: 4 back-to-back sets, i_ready low for cycles 0..3
    bp_a   = '{9, 15, 0, 5};
    bp_b   = '{10, 15, 5, 6};
    bp_inc = '{0, 1, 0, 1};
    bp_exp[0] = pack(12, 0, 0, 0);
    bp_exp[1] = pack(ovf_exp(8), 0, 1, 0);
    bp_exp[2] = pack(0, 1, 0, 0);
    bp_exp[3] = pack(5, 0, 0, 0);
    @(posedge clk); #1;
    next_in = 0;
    n_out   = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      i_ready = (cyc >= 4);
      i_valid = (next_in < 4);
      if (next_in < 4) begin
        i_exponente_1 = bp_a[next_in][NB_EXP-1:0];
        i_exponente_2 = bp_b[next_in][NB_EXP-1:0];
        i_norm_inc    = bp_inc[next_in];
      end
      #1;
      if (cyc == 2 || cyc == 3) begin
        chk($sformatf("bp_stall_ready_c%0d", cyc), int'(o_ready), 0);
        chk($sformatf("bp_stall_valid_c%0d", cyc), int'(o_valid), 1);
      end
      if (cyc == 4) chk("bp_full_drain_ready", int'(o_ready), 1);
      will_in  = i_valid && o_ready;
      will_out = o_valid && i_ready;
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("bp_extra_out_c%0d", cyc), 1, 0);
        end else begin
          chk_out($sformatf("bp_c%0d", cyc), exp_q[0]);
        end
      end
      if (will_out && exp_q.size() != 0) begin
        chk($sformatf("bp_out%0d_cycle", n_out), cyc, 4 + n_out);
        void'(exp_q.pop_front());
        n_out++;
      end
      if (will_in) begin
        exp_q.push_back(bp_exp[next_in]);
        next_in++;
      end
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    chk("bp_accepted", next_in, 4);
    chk("bp_emitted", n_out, 4);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Reset mid-stream with both stages full
    i_ready       = 1'b0;
    i_valid       = 1'b1;
    i_exponente_1 = 4'd15;
    i_exponente_2 = 4'd15;
    i_norm_inc    = 1'b1;
    @(posedge clk); #1;
    i_exponente_1 = 4'd3;
    i_exponente_2 = 4'd2;
    i_norm_inc    = 1'b0;
    @(posedge clk); #1;
    i_valid = 1'b0;
    chk("mid_full_valid", int'(o_valid), 1);
    chk("mid_full_ready", int'(o_ready), 0);
    #2;
    i_reset = 1'b1;
    #1;
    chk("mid_rst_valid", int'(o_valid), 0);
    chk_out("mid_rst", pack(0, 0, 0, 0));
    @(posedge clk); #1;
    i_reset = 1'b0;
    i_ready = 1'b1;
    #1;
    chk("mid_rel_ready", int'(o_ready), 1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("mid_no_stale_%0d", k), int'(o_valid), 0);
    end
    run_one("post_rst", 9, 10, 0, pack(12, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
